// File: rtl/trace_capture_pkg.sv
// Shared types for the trace capture FIFO.
// This package holds the capture FSM state encoding.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM with one write port and a registered read port.
// The single-cycle read latency lets synthesis infer block RAM.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_capture_fifo.sv
// Captures a fixed-length burst of sensor samples after a trigger into on-chip RAM
// and exposes a pop-style read port for the downstream flusher.
import trace_capture_pkg::*;

module trace_capture_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  arm,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] sensor_data,
    input  logic                  sensor_valid,
    output logic                  capture_busy,
    output logic                  capture_done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  fill_level,
    input  logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_empty,
    output logic                  fifo_data_valid
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);

    capture_state_t        state;
    logic [CNT_WIDTH-1:0]  num_latched;
    logic [CNT_WIDTH-1:0]  sample_cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [CNT_WIDTH-1:0]  fill;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  overflow_q;
    logic                  vld_p1;
    logic                  take_sample;
    logic                  full;
    logic                  wr_en;
    logic                  rd_accept;

    // The trigger cycle itself counts as a capture cycle.
    always_comb begin
        take_sample = sensor_valid && ((state == ARMED && trigger) || state == CAPTURE);
        full        = (fill == FULL_LEVEL);
        wr_en       = take_sample && !full;
        rd_accept   = fifo_rd_en && (fill != '0);
        cnt_next    = sample_cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= IDLE;
            num_latched <= '0;
            sample_cnt  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        num_latched <= num_samples;
                        sample_cnt  <= '0;
                        overflow_q  <= 1'b0;
                        state       <= (num_samples == '0) ? DONE : ARMED;
                    end
                end
                ARMED, CAPTURE: begin
                    if (take_sample) begin
                        sample_cnt <= cnt_next;
                        if (full) begin
                            overflow_q <= 1'b1;
                        end
                        state <= (cnt_next == num_latched) ? DONE : CAPTURE;
                    end else if (state == ARMED && trigger) begin
                        state <= CAPTURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pointers and level; dropped samples never move wr_ptr.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            unique case ({wr_en, rd_accept})
                2'b10:   fill <= fill + CNT_WIDTH'(1);
                2'b01:   fill <= fill - CNT_WIDTH'(1);
                default: fill <= fill;
            endcase
            vld_p1 <= rd_accept;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (sensor_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (fifo_dout)
    );

    assign capture_busy    = (state == ARMED) || (state == CAPTURE);
    assign capture_done    = (state == DONE);
    assign overflow        = overflow_q;
    assign fill_level      = fill;
    assign fifo_empty      = (fill == '0);
    assign fifo_data_valid = vld_p1;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Randomized bench for trace_capture_fifo checked every cycle against a queue-based model.
module tb_trace_capture_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          arm = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          trigger = 1'b0;
    logic [DW-1:0] sensor_data = '0;
    logic          sensor_valid = 1'b0;
    logic          fifo_rd_en = 1'b0;
    logic          capture_busy, capture_done, overflow, fifo_empty, fifo_data_valid;
    logic [CW-1:0] fill_level;
    logic [DW-1:0] fifo_dout;

    trace_capture_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .arm             (arm),
        .num_samples     (num_samples),
        .trigger         (trigger),
        .sensor_data     (sensor_data),
        .sensor_valid    (sensor_valid),
        .capture_busy    (capture_busy),
        .capture_done    (capture_done),
        .overflow        (overflow),
        .fill_level      (fill_level),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_dout       (fifo_dout),
        .fifo_empty      (fifo_empty),
        .fifo_data_valid (fifo_data_valid)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
    int            m_phase = 0;
    int            m_left = 0;
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 0;
    bit            m_dv = 0;
    bit            m_live = 0;
    logic [DW-1:0] m_dout;
    bit            m_pop, m_full, m_take;
    logic [DW-1:0] got[$];

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_phase = 0;
            m_left  = 0;
            m_q.delete();
            m_ovf   = 0;
            m_dv    = 0;
            m_live  = 1;
        end else if (m_live) begin
            m_pop  = fifo_rd_en && (m_q.size() > 0);
            m_full = (m_q.size() == DEPTH);
            m_take = (m_phase == 1 && trigger) || m_phase == 2;
            m_dv   = m_pop;
            if (m_pop) m_dout = m_q.pop_front();
            if (m_take && sensor_valid && !m_full) m_q.push_back(sensor_data);
            if ((m_phase == 0 || m_phase == 3) && arm) begin
                m_left  = int'(num_samples);
                m_ovf   = 0;
                m_phase = (num_samples == 0) ? 3 : 1;
            end else if (m_take) begin
                m_phase = 2;
                if (sensor_valid) begin
                    m_left--;
                    if (m_full) m_ovf = 1;
                    if (m_left == 0) m_phase = 3;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (m_live) begin
            chk("busy", capture_busy, (m_phase == 1 || m_phase == 2));
            chk("done", capture_done, (m_phase == 3));
            chk("overflow", overflow, m_ovf);
            chk("fill_level", fill_level, m_q.size());
            chk("empty", fifo_empty, (m_q.size() == 0));
            chk("data_valid", fifo_data_valid, m_dv);
            if (m_dv) chk("dout", fifo_dout, m_dout);
            if (fifo_data_valid === 1'b1) got.push_back(fifo_dout);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cyc(1);
        aresetn = 1'b1;
    endtask

    task automatic do_arm(input int n);
        arm = 1'b1;
        num_samples = CW'(n);
        cyc(1);
        arm = 1'b0;
    endtask

    int sent;
    int guard;

    initial begin
        cyc(3);
        aresetn = 1'b1;
        cyc(1);
        chk("reset_fill", fill_level, 0);
        chk("reset_empty", fifo_empty, 1);
        chk("reset_busy", capture_busy, 0);
        chk("reset_done", capture_done, 0);

        // Basic 8-sample burst, then drain.
        got.delete();
        do_arm(8);
        for (int i = 0; i < 8; i++) begin
            trigger = 1'b1;
            sensor_valid = 1'b1;
            sensor_data = DW'(i);
            cyc(1);
            if (i == 6) chk("t1_not_done_early", capture_done, 0);
        end
        trigger = 1'b0;
        sensor_valid = 1'b0;
        chk("t1_done", capture_done, 1);
        chk("t1_fill", fill_level, 8);
        chk("t1_model_fill", m_q.size(), 8);
        fifo_rd_en = 1'b1;
        cyc(8);
        fifo_rd_en = 1'b0;
        cyc(2);
        chk("t1_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_word", got[i], i);
        chk("t1_empty", fifo_empty, 1);

        // Overflow: 20 samples into a 16-deep FIFO with random gaps.
        got.delete();
        do_arm(20);
        trigger = 1'b1;
        sent = 0;
        guard = 0;
        while (sent < 20 && guard < 300) begin
            sensor_valid = ($urandom_range(0, 3) != 0);
            sensor_data = DW'(sent);
            cyc(1);
            if (sensor_valid) sent++;
            guard++;
        end
        trigger = 1'b0;
        sensor_valid = 1'b0;
        chk("t2_sent", sent, 20);
        chk("t2_done", capture_done, 1);
        chk("t2_fill", fill_level, 16);
        chk("t2_overflow", overflow, 1);
        guard = 0;
        while (got.size() < 16 && guard < 300) begin
            fifo_rd_en = ($urandom_range(0, 1) != 0);
            cyc(1);
            guard++;
        end
        fifo_rd_en = 1'b0;
        cyc(2);
        chk("t2_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("t2_word", got[i], i);

        // Zero-length capture and triggers outside ARMED.
        do_arm(0);
        chk("t3_done", capture_done, 1);
        chk("t3_busy", capture_busy, 0);
        trigger = 1'b1;
        sensor_valid = 1'b1;
        cyc(3);
        chk("t3_fill_done", fill_level, 0);
        trigger = 1'b0;
        sensor_valid = 1'b0;
        do_reset();
        trigger = 1'b1;
        sensor_valid = 1'b1;
        cyc(3);
        chk("t3_fill_idle", fill_level, 0);
        trigger = 1'b0;
        sensor_valid = 1'b0;

        // Concurrent pop and write at level 1, then pop on empty.
        do_arm(4);
        trigger = 1'b1;
        sensor_valid = 1'b1;
        sensor_data = 100;
        cyc(1);
        trigger = 1'b0;
        sensor_valid = 1'b0;
        cyc(1);
        chk("t4_fill_one", fill_level, 1);
        got.delete();
        sensor_valid = 1'b1;
        sensor_data = 101;
        fifo_rd_en = 1'b1;
        cyc(1);
        sensor_valid = 1'b0;
        fifo_rd_en = 1'b0;
        cyc(1);
        chk("t4_pop_count", got.size(), 1);
        if (got.size() > 0) chk("t4_old_word", got[0], 100);
        chk("t4_fill_kept", fill_level, 1);
        fifo_rd_en = 1'b1;
        cyc(1);
        fifo_rd_en = 1'b1;
        cyc(1);
        chk("t4_empty_no_valid", fifo_data_valid, 0);
        fifo_rd_en = 1'b0;
        cyc(1);
        chk("t4_total_pops", got.size(), 2);
        if (got.size() > 1) chk("t4_new_word", got[1], 101);

        // Reset in the middle of a capture.
        do_reset();
        do_arm(10);
        trigger = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sensor_valid = 1'b1;
            sensor_data = DW'(200 + i);
            cyc(1);
        end
        trigger = 1'b0;
        sensor_valid = 1'b0;
        chk("t5_fill_pre", fill_level, 5);
        chk("t5_busy_pre", capture_busy, 1);
        do_reset();
        chk("t5_busy", capture_busy, 0);
        chk("t5_empty", fifo_empty, 1);
        chk("t5_fill", fill_level, 0);
        chk("t5_overflow", overflow, 0);

        // Three 10-sample rounds so both pointers wrap.
        for (int r = 0; r < 3; r++) begin
            got.delete();
            do_arm(10);
            trigger = 1'b1;
            for (int i = 0; i < 10; i++) begin
                sensor_valid = 1'b1;
                sensor_data = DW'(r * 1000 + i);
                cyc(1);
            end
            trigger = 1'b0;
            sensor_valid = 1'b0;
            fifo_rd_en = 1'b1;
            cyc(10);
            fifo_rd_en = 1'b0;
            cyc(2);
            chk("t6_count", got.size(), 10);
            for (int i = 0; i < 10 && i < got.size(); i++) chk("t6_word", got[i], r * 1000 + i);
        end

        // Free-running random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            arm = ($urandom_range(0, 15) == 0);
            num_samples = CW'($urandom_range(0, 20));
            trigger = ($urandom_range(0, 3) == 0);
            sensor_valid = ($urandom_range(0, 1) != 0);
            sensor_data = $urandom;
            fifo_rd_en = ($urandom_range(0, 2) == 0);
            aresetn = ($urandom_range(0, 199) != 0);
            cyc(1);
        end
        arm = 1'b0;
        trigger = 1'b0;
        sensor_valid = 1'b0;
        fifo_rd_en = 1'b0;
        aresetn = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
